// File: rtl/nibble_bus_pkg.sv
// Shared nibble-bus definitions used by both the driver and the receiver side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibble_bus_pkg;

    // Width of one bus transfer; words are assembled LSB-nibble first.
    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered show-ahead FIFO: the head entry is visible on pop_dat whenever it is non-empty.
// Latency: a push becomes visible on pop_dat/level in the next cycle.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (pointers/level only)
//   push, push_dat      write request and data
//   pop                 read request (ignored while empty)
//   pop_dat             head entry, zero while empty
//   full, empty, level  occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zero while empty so the output is deterministic after reset without clearing storage.
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/nibble_bus_rx.sv
// Nibble bus receiver: assembles enabled nibbles LSB-first into words and streams them out via a FIFO.
// Latency: last nibble in cycle t -> m_valid/m_data in cycle t+1 (FIFO empty).
// Backpressure: m_ready stalls the FIFO head; a word completing while full without a pop is dropped, setting overflow.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bus, bus_en        shared nibble bus and its driver enable
//   m_data/m_valid/m_ready  output word stream (show-ahead)
//   frame_err          one-cycle pulse after a frame is cut short
//   overflow           sticky dropped-word flag, cleared only by rst
//   level              FIFO occupancy
module nibble_bus_rx
    import nibble_bus_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  tri   [NIBBLE_W-1:0]        bus,
    input  logic                       bus_en,
    output logic [NIBBLE_W*NIBBLES-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       frame_err,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     word_q, word_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic             push, pop, fifo_full, fifo_empty;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // ---- next state ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (bus_en) begin
                    word_d[NIBBLE_W-1:0] = bus;
                    cnt_d   = CNT_W'(1);
                    state_d = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (bus_en) begin
                    word_d[cnt_q*NIBBLE_W +: NIBBLE_W] = bus;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Gap inside a frame: drop the partial word.
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ---- outputs / flags ----
    always_comb begin
        // word_d already carries the final nibble, so the complete word is pushed this cycle.
        push        = (state_q == ASSEMBLE) && bus_en && (cnt_q == LAST);
        frame_err_d = (state_q == ASSEMBLE) && !bus_en;
        overflow_d  = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pop       = m_valid && m_ready;
    assign m_valid   = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (word_d),
        .pop      (pop),
        .pop_dat  (m_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

endmodule

// File: tb/tb_nibble_bus_rx.sv
// Self-checking bench for nibble_bus_rx: directed scenarios then random traffic against a frame-level model.
// Latency: n/a.
// Backpressure: m_ready is driven both directed and random.
module tb_nibble_bus_rx;

    localparam int NIB   = 2;
    localparam int DEPTH = 4;
    localparam int W     = 4 * NIB;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_en = 1'b0;
    logic [3:0]    drv = 4'h0;
    logic          m_ready = 1'b0;
    wire  [3:0]    bus;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] level;

    assign bus = bus_en ? drv : 4'bz;

    nibble_bus_rx #(.NIBBLES(NIB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bus_en    (bus_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model state: nibbles of the frame in flight, expected words, flags.
    logic [3:0]   frame[$];
    logic [W-1:0] exp_q[$];
    int           mdl_level = 0;
    bit           mdl_ov = 1'b0;
    bit           mdl_fe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is whatever NIB consecutive enabled nibbles were, LSB first.
    always @(posedge clk) begin
        bit           mpop, mpush, fe_n;
        logic [W-1:0] w;
        if (rst) begin
            frame.delete();
            exp_q.delete();
            mdl_level = 0;
            mdl_ov    = 1'b0;
            mdl_fe    = 1'b0;
        end else begin
            mpop  = (mdl_level > 0) && m_ready;
            mpush = 1'b0;
            fe_n  = 1'b0;
            if (bus_en) begin
                frame.push_back(bus);
                if (frame.size() == NIB) begin
                    w = '0;
                    for (int i = 0; i < NIB; i++) w = w | (W'(frame[i]) << (4 * i));
                    frame.delete();
                    if (mdl_level < DEPTH || mpop) begin
                        exp_q.push_back(w);
                        mpush = 1'b1;
                    end else begin
                        mdl_ov = 1'b1;
                    end
                end
            end else begin
                fe_n = (frame.size() != 0);
                frame.delete();
            end
            mdl_level = mdl_level + int'(mpush) - int'(mpop);
            mdl_fe    = fe_n;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_on) begin
            chk("level", 32'(level), 32'(mdl_level));
            chk("m_valid", 32'(m_valid), 32'(mdl_level != 0));
            chk("overflow", 32'(overflow), 32'(mdl_ov));
            chk("frame_err", 32'(frame_err), 32'(mdl_fe));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e));
                end
            end
        end
    end

    task automatic cyc(input logic en, input logic [3:0] n, input logic rdy);
        bus_en  = en;
        drv     = n;
        m_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bus_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, rdy);
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        do_reset();

        // Single word 0xA5; check latency directly.
        cyc(1'b1, 4'h5, 1'b1);
        cyc(1'b1, 4'hA, 1'b1);
        chk("lat_m_valid", 32'(m_valid), 32'h1);
        chk("lat_m_data", 32'(m_data), 32'hA5);
        idle(3, 1'b1);

        // Back-to-back 1..6 -> 0x21, 0x43, 0x65.
        for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i), 1'b1);
        idle(3, 1'b1);

        // Truncated frame then a good one.
        cyc(1'b1, 4'h7, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);
        chk("trunc_frame_err", 32'(frame_err), 32'h1);
        cyc(1'b1, 4'h1, 1'b1);
        chk("trunc_pulse_once", 32'(frame_err), 32'h0);
        cyc(1'b1, 4'h2, 1'b1);
        idle(3, 1'b1);

        // Overflow: five words into a four-entry FIFO with no consumer.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 4'(i), 1'b0);
            cyc(1'b1, 4'h0, 1'b0);
        end
        idle(1, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        idle(6, 1'b1);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        do_reset();

        // Full FIFO with a pop in the same cycle a word completes.
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 8), 1'b0);
        cyc(1'b1, 4'hE, 1'b0);
        cyc(1'b1, 4'hD, 1'b1);
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_ovf", 32'(overflow), 32'h0);
        idle(6, 1'b1);

        // Reset mid-frame, then 0xC,0x3 -> 0x3C.
        cyc(1'b1, 4'h9, 1'b1);
        do_reset();
        cyc(1'b1, 4'hC, 1'b1);
        cyc(1'b1, 4'h3, 1'b1);
        chk("rstmid_m_data", 32'(m_data), 32'h3C);
        idle(3, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc(($urandom_range(0, 9) < 8), 4'($urandom), $urandom_range(0, 1) == 1);
        end

        idle(10, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        chk("drain_level", 32'(level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_bus_rx.md
# nibble_bus_rx

Receiving end of the shared 4-bit tristate nibble bus. A driver enables its buffer onto `bus` with `bus_en`. This block samples the enabled nibbles, assembles them LSB-first into words, buffers the words in a small FIFO and presents them on a valid/ready stream. It sits on the far side of the bus from the tristate drivers and is the only consumer of bus traffic.

## Interface
Parameters:
- `NIBBLES`, 2: nibbles per word; word width `W = 4*NIBBLES`; legal range 2..8.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `bus`  in  tri [3:0]  shared nibble bus; meaningful only while `bus_en`=1, may float (Z) otherwise.
- `bus_en`  in  1  driver enable; 1 = a valid nibble is on `bus` this cycle.
- `m_data`  out  W  head-of-FIFO word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid`=1.
- `frame_err`  out  1  one-cycle pulse: frame truncated.
- `overflow`  out  1  sticky: a completed word was dropped; cleared only by `rst`.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- FSM states are `IDLE` and `ASSEMBLE`, plus a nibble counter `cnt` running 0..NIBBLES-1.
- IDLE with `bus_en`=1:
  - Store `bus` into word bits [3:0].
  - Set `cnt`=1 and go to ASSEMBLE.
- IDLE with `bus_en`=0: `bus` is ignored; stay in IDLE.
- ASSEMBLE with `bus_en`=1:
  - Store `bus` into bits [4*cnt+3 : 4*cnt].
  - If `cnt`=NIBBLES-1, the word is complete: push it, clear `cnt` and return to IDLE.
  - Otherwise increment `cnt`.
- ASSEMBLE with `bus_en`=0:
  - Discard the partial word and return to IDLE.
  - Pulse `frame_err` for exactly one cycle, in the cycle after the gap.
- Back-to-back frames are supported. When `bus_en` stays high after a completed word, the next nibble starts a new word with no idle cycle.
- The bus value is sampled as-is. X/Z detection is out of scope.
- Push, FIFO not full: the word is written.
- Push, FIFO full, pop in the same cycle: the word is written and `level` is unchanged.
- Push, FIFO full, no pop: the word is dropped and `overflow` is set.
- Pop occurs when `m_valid`=1 and `m_ready`=1.
- Push and pop in the same cycle with a non-full FIFO: both are performed and `level` is unchanged.
- `m_valid` = (`level` != 0). `m_data` holds the head entry (show-ahead) and is stable while `m_valid`=1 and `m_ready`=0.
- Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values, applied on the first rising edge with `rst`=1:
  - FSM in IDLE, `cnt`=0.
  - `m_valid`=0, `m_data`=0, `frame_err`=0, `overflow`=0, `level`=0.
  - FIFO contents are not cleared, but pointers are zeroed.
- `rst` asserted mid-frame discards the partial word; no `frame_err` is raised.
- Latency: with the last nibble on `bus` in cycle t and the FIFO empty, `m_valid`=1 in cycle t+1 with the full word on `m_data`.
- Sustained throughput is one word per NIBBLES cycles. Output acceptance is one word per cycle.
- `frame_err` is asserted in cycle t+1 when `bus_en` is 0 in cycle t while in ASSEMBLE.
- `overflow` rises in cycle t+1 after the dropped push in cycle t.
- No combinational path from `bus`/`bus_en` to any output. `m_valid` does not depend combinationally on `m_ready`.

## Structure
- Shared package `nibble_bus_pkg` holds:
  - `NIBBLE_W = 4`.
  - `typedef enum logic {IDLE, ASSEMBLE} rx_state_t`.
- The package is shared with the bus driver side so that nibble width and ordering are defined once.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` is a registered show-ahead FIFO with push/pop/full/empty/level. It is reused for future bus-side buffering.
- The top level contains the FSM, the assembly register and the flag logic.

## Test plan
- NIBBLES=2. `bus_en`=1 for 2 cycles with `bus`=0x5 then 0xA, `m_ready`=1 → `m_data`=0xA5, `m_valid` high one cycle after the last nibble, `frame_err`=0.
- Back-to-back: 6 continuous nibbles 1,2,3,4,5,6 → words 0x21, 0x43, 0x65 in order, with no gap in acceptance.
- Truncation: nibble 0x7, then `bus_en`=0, then nibbles 0x1,0x2 → one `frame_err` pulse; only word 0x21 is output.
- Overflow: `m_ready`=0, push DEPTH+1 words (0x01..0x05 with DEPTH=4) → `level`=4 and `overflow`=1. Raising `m_ready` then yields 0x01..0x04 only, and `overflow` stays 1.
- Full + simultaneous pop: FIFO full, `m_ready`=1 on the same cycle a word completes → the word is accepted, `level` stays 4, `overflow` stays 0.
- Reset mid-frame: `rst`=1 after the first nibble → all outputs return to reset values; the next full frame (0xC, 0x3) outputs 0x3C.
